// File: rtl/pipes_pkg.sv
// Shared types for the pipes game datapath: the pipe record stored in
// pipes_list, the frame sequencer state encoding and the playfield defaults.
package pipes_pkg;

    // One pipe: signed left-edge x (may go negative while sliding off screen)
    // and the vertical position of its gap.
    typedef struct packed {
        logic signed [10:0] x;
        logic [9:0]         gap_y;
    } pipe_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CLEAR      = 3'd1,
        ST_SPAWN      = 3'd2,
        ST_ITER_START = 3'd3,
        ST_ITER       = 3'd4,
        ST_DONE       = 3'd5
    } sched_state_t;

    localparam int SCREEN_W_DEF = 640;
    localparam int PIPE_W_DEF   = 52;
    localparam int BIRD_X_DEF   = 160;
    localparam int GAP_MIN_DEF  = 80;
    localparam int GAP_MAX_DEF  = 320;
    localparam int CAPACITY_DEF = 16;

endpackage

// File: rtl/pipes_scheduler.sv
// Per-frame sequencer for pipes_list: on each accepted frame tick it may
// spawn a pipe at the right edge, then walks the list once, scrolling every
// pipe left by speed, dropping pipes that left the screen and pulsing
// score_inc for every pipe that crosses the bird column.
module pipes_scheduler
    import pipes_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int PIPE_W   = PIPE_W_DEF,
    parameter int BIRD_X   = BIRD_X_DEF,
    parameter int GAP_MIN  = GAP_MIN_DEF,
    parameter int GAP_MAX  = GAP_MAX_DEF,
    parameter int CAPACITY = CAPACITY_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         frame_tick,
    input  logic         running,
    input  logic         restart,
    input  logic [3:0]   speed,
    input  logic [7:0]   spawn_period,
    input  logic [9:0]   rand_gap,
    input  logic [4:0]   list_count,
    output logic         list_clear,
    output logic         list_insert_en,
    output pipe_t        list_insert_data,
    output logic         list_iter_start,
    input  logic         list_iter_done,
    input  pipe_t        list_iter_out,
    output pipe_t        list_iter_in,
    output logic         list_iter_remove,
    output logic         busy,
    output logic         frame_done,
    output logic         score_inc,
    output logic         overrun,
    output sched_state_t dbg_state
);

    localparam logic signed [10:0] SPAWN_X = 11'(SCREEN_W);
    localparam logic signed [10:0] OFF_X   = -(11'(PIPE_W));
    localparam logic signed [10:0] BIRD_XS = 11'(BIRD_X);
    localparam logic [9:0]         GAP_LO  = 10'(GAP_MIN);
    localparam logic [9:0]         GAP_HI  = 10'(GAP_MAX);
    localparam logic [4:0]         CAP     = 5'(CAPACITY);

    sched_state_t       state;
    sched_state_t       next_state;
    logic [7:0]         spawn_cnt;
    logic [7:0]         reload_cnt;
    logic [9:0]         gap_clamped;
    logic               elem_valid;
    logic signed [10:0] old_x;
    logic signed [10:0] new_x;
    logic               crossing;

    assign dbg_state = state;

    // Iterate handshake: while in ITER, pipes_list holds list_iter_out valid
    // whenever list_iter_done is low, and this block always accepts it in the
    // same cycle (ready is implicitly 1), returning list_iter_in and
    // list_iter_remove combinationally; pipes_list advances on every such
    // cycle. list_iter_done high means no element is presented that cycle.
    always_comb begin
        elem_valid       = (state == ST_ITER) && !list_iter_done;
        old_x            = list_iter_out.x;
        new_x            = old_x - $signed({7'd0, speed});
        list_iter_in     = '0;
        list_iter_remove = 1'b0;
        crossing         = 1'b0;
        if (elem_valid) begin
            list_iter_in.x     = new_x;
            list_iter_in.gap_y = list_iter_out.gap_y;
            list_iter_remove   = (new_x < OFF_X);
            // A pipe removed in the same step still scores if it crossed.
            crossing           = (old_x >= BIRD_XS) && (new_x < BIRD_XS);
        end
    end

    // Spawn helpers: gap clamp and timer reload (period 0 behaves as 1).
    always_comb begin
        gap_clamped = rand_gap;
        if (rand_gap < GAP_LO) begin
            gap_clamped = GAP_LO;
        end else if (rand_gap > GAP_HI) begin
            gap_clamped = GAP_HI;
        end
        reload_cnt = (spawn_period == 8'd0) ? 8'd0 : spawn_period - 8'd1;
    end

    // Next-state selection; restart aborts from any state.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:       if (frame_tick && running) next_state = ST_SPAWN;
            ST_CLEAR:      next_state = ST_IDLE;
            ST_SPAWN:      next_state = ST_ITER_START;
            ST_ITER_START: next_state = ST_ITER;
            ST_ITER:       if (list_iter_done) next_state = ST_DONE;
            ST_DONE:       next_state = ST_IDLE;
            default:       next_state = ST_IDLE;
        endcase
        if (restart) begin
            next_state = ST_CLEAR;
        end
    end

    // State register, spawn timer and registered outputs decoded from the
    // state being entered, so each pulse lines up with its state cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            spawn_cnt        <= 8'd0;
            busy             <= 1'b0;
            list_clear       <= 1'b0;
            list_iter_start  <= 1'b0;
            frame_done       <= 1'b0;
            score_inc        <= 1'b0;
            overrun          <= 1'b0;
            list_insert_en   <= 1'b0;
            list_insert_data <= '0;
        end else begin
            state           <= next_state;
            busy            <= (next_state != ST_IDLE);
            list_clear      <= (next_state == ST_CLEAR);
            list_iter_start <= (next_state == ST_ITER_START);
            frame_done      <= (next_state == ST_DONE);
            score_inc       <= crossing;
            list_insert_en  <= 1'b0;

            if (next_state == ST_CLEAR) begin
                spawn_cnt <= 8'd0;
                overrun   <= 1'b0;
            end else if ((state != ST_IDLE) && frame_tick) begin
                overrun <= 1'b1;
            end

            // Spawn decision uses the inputs of the accepted tick cycle;
            // pipes_list stores the record during the SPAWN cycle. A full
            // list leaves the timer at 0 so the spawn retries next frame.
            if (next_state == ST_SPAWN) begin
                if (spawn_cnt == 8'd0) begin
                    if (list_count < CAP) begin
                        list_insert_en         <= 1'b1;
                        list_insert_data.x     <= SPAWN_X;
                        list_insert_data.gap_y <= gap_clamped;
                        spawn_cnt              <= reload_cnt;
                    end
                end else begin
                    spawn_cnt <= spawn_cnt - 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipes_scheduler.sv
// Bench for pipes_scheduler: a behavioural stand-in for pipes_list plus a
// frame-level reference model of the game rules.
`timescale 1ns/1ps
module tb_pipes_scheduler;
    import pipes_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         frame_tick = 1'b0;
    logic         running = 1'b0;
    logic         restart = 1'b0;
    logic [3:0]   speed = 4'd0;
    logic [7:0]   spawn_period = 8'd1;
    logic [9:0]   rand_gap = 10'd200;
    logic [4:0]   list_count;
    logic         list_clear, list_insert_en, list_iter_start, list_iter_done;
    logic         list_iter_remove, busy, frame_done, score_inc, overrun;
    pipe_t        list_insert_data, list_iter_out, list_iter_in;
    sched_state_t dbg_state;

    pipes_scheduler dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .running(running),
        .restart(restart), .speed(speed), .spawn_period(spawn_period),
        .rand_gap(rand_gap), .list_count(list_count), .list_clear(list_clear),
        .list_insert_en(list_insert_en), .list_insert_data(list_insert_data),
        .list_iter_start(list_iter_start), .list_iter_done(list_iter_done),
        .list_iter_out(list_iter_out), .list_iter_in(list_iter_in),
        .list_iter_remove(list_iter_remove), .busy(busy), .frame_done(frame_done),
        .score_inc(score_inc), .overrun(overrun), .dbg_state(dbg_state)
    );

    // ---------------- pipes_list stand-in ----------------
    // A spawned pipe waits in pend[] and joins the list when the pass ends,
    // so it is not scrolled in the frame that created it.
    pipe_t mem [0:15];
    pipe_t nxt [0:15];
    pipe_t pend [0:15];
    pipe_t pre_buf [0:15];
    int    mem_n = 0, nxt_n = 0, pend_n = 0, idx = 0, pre_n = 0;
    int    pre_seq = 0, pre_seen = 0, score_seen = 0;
    bit    iterating = 1'b0;
    pipe_t ins_log[$];

    assign list_count = 5'(mem_n + pend_n);

    always_comb begin
        list_iter_out  = '0;
        list_iter_done = 1'b0;
        if (iterating) begin
            if (idx < mem_n) list_iter_out = mem[idx];
            else             list_iter_done = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (score_inc) score_seen <= score_seen + 1;
        if (list_insert_en) ins_log.push_back(list_insert_data);
        if (pre_seq != pre_seen) begin
            for (int i = 0; i < 16; i++) mem[i] <= pre_buf[i];
            mem_n <= pre_n; pend_n <= 0; iterating <= 1'b0; pre_seen <= pre_seq;
        end else if (list_clear) begin
            mem_n <= 0; pend_n <= 0; iterating <= 1'b0;
        end else begin
            if (list_insert_en && (pend_n < 16)) begin
                pend[pend_n] <= list_insert_data;
                pend_n <= pend_n + 1;
            end
            if (list_iter_start) begin
                iterating <= 1'b1; idx <= 0; nxt_n <= 0;
            end else if (iterating) begin
                if (idx < mem_n) begin
                    if (!list_iter_remove) begin
                        nxt[nxt_n] <= list_iter_in;
                        nxt_n <= nxt_n + 1;
                    end
                    idx <= idx + 1;
                end else begin
                    for (int i = 0; i < 16; i++) begin
                        if (i < nxt_n) mem[i] <= nxt[i];
                        else if (i < nxt_n + pend_n) mem[i] <= pend[i - nxt_n];
                    end
                    mem_n <= nxt_n + pend_n; pend_n <= 0; iterating <= 1'b0;
                end
            end
        end
    end

    // ---------------- reference model (frame level) ----------------
    int exp_x[$];
    int exp_g[$];
    int exp_cnt = 0;
    int checks = 0;
    int failures = 0;

    task automatic model_tick(output int lat, output int nscore, output int ins, output pipe_t ins_d);
        int n_before, sp, g, nx;
        int kx[$];
        int kg[$];
        n_before = exp_x.size();
        sp = int'(speed);
        g = 0; ins = 0; ins_d = '0;
        if (exp_cnt == 0) begin
            if (n_before < 16) begin
                g = int'(rand_gap);
                if (g < 80) g = 80;
                else if (g > 320) g = 320;
                ins = 1; ins_d.x = 11'sd640; ins_d.gap_y = 10'(g);
                exp_cnt = ((spawn_period == 8'd0) ? 1 : int'(spawn_period)) - 1;
            end
        end else begin
            exp_cnt = exp_cnt - 1;
        end
        nscore = 0;
        foreach (exp_x[i]) begin
            nx = exp_x[i] - sp;
            if (exp_x[i] >= 160 && nx < 160) nscore++;
            if (nx >= -52) begin kx.push_back(nx); kg.push_back(exp_g[i]); end
        end
        if (ins == 1) begin kx.push_back(640); kg.push_back(g); end
        exp_x = kx; exp_g = kg;
        lat = 4 + n_before;
    endtask

    function automatic int list_diff();
        int d = 0;
        if (mem_n != exp_x.size()) return 100;
        for (int i = 0; i < mem_n; i++)
            if (int'($signed(mem[i].x)) != exp_x[i] || int'(mem[i].gap_y) != exp_g[i]) d++;
        return d;
    endfunction

    function automatic logic [49:0] outs_vec();
        return {busy, frame_done, score_inc, list_clear, list_insert_en, list_insert_data,
                list_iter_start, list_iter_remove, list_iter_in, overrun};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_restart();
        @(negedge clk); restart = 1'b1;
        @(negedge clk); restart = 1'b0;
        @(negedge clk);
        exp_x.delete(); exp_g.delete(); exp_cnt = 0;
    endtask

    task automatic load_pipes(input int xs[$]);
        @(negedge clk);
        for (int i = 0; i < 16; i++) pre_buf[i] = '0;
        exp_x.delete(); exp_g.delete();
        foreach (xs[i]) begin
            pre_buf[i].x = 11'(xs[i]); pre_buf[i].gap_y = 10'(100 + i);
            exp_x.push_back(xs[i]); exp_g.push_back(100 + i);
        end
        pre_n = xs.size();
        pre_seq = pre_seq + 1;
        @(negedge clk); @(negedge clk);
    endtask

    // Drives one tick, optionally a second tick at cycle inject_at, and waits
    // (bounded) for frame_done. lat = -1 when frame_done never arrives.
    task automatic run_tick(input int inject_at, output int lat, output int nscore, output int nins, output pipe_t last_ins);
        int s0, i0;
        s0 = score_seen; i0 = ins_log.size();
        lat = -1;
        @(negedge clk); frame_tick = 1'b1;
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            frame_tick = (c == inject_at);
            if (frame_done) begin lat = c; break; end
        end
        frame_tick = 1'b0;
        nscore = score_seen - s0;
        nins = ins_log.size() - i0;
        last_ins = (nins > 0) ? ins_log[$] : '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (outs_vec() !== 50'd0) begin failures++; $display("FAIL reset_outs got=%h exp=0", outs_vec()); end
        checks++;
        if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_spawn_cadence();
        int lat, sc, ni, el, es, ei;
        pipe_t li, ed;
        int exp_ins_pat[4] = '{1, 0, 0, 1};
        running = 1'b1; spawn_period = 8'd3; speed = 4'd2; rand_gap = 10'd200;
        do_restart();
        for (int t = 0; t < 4; t++) begin
            model_tick(el, es, ei, ed);
            run_tick(0, lat, sc, ni, li);
            checks++;
            if (lat !== el) begin failures++; $display("FAIL cadence_latency tick=%0d got=%0d exp=%0d", t + 1, lat, el); end
            checks++;
            if (ni !== exp_ins_pat[t]) begin failures++; $display("FAIL cadence_insert tick=%0d got=%0d exp=%0d", t + 1, ni, exp_ins_pat[t]); end
            if (ni == 1) begin
                checks++;
                if (li.x !== 11'sd640) begin failures++; $display("FAIL cadence_spawn_x tick=%0d got=%0d exp=640", t + 1, li.x); end
            end
        end
        checks++;
        if (mem_n !== 2 || mem[0].x !== 11'sd634 || mem[1].x !== 11'sd640)
            begin failures++; $display("FAIL cadence_list n=%0d x0=%0d x1=%0d exp n=2 x0=634 x1=640", mem_n, mem[0].x, mem[1].x); end
    endtask

    task automatic test_gap_clamp();
        int lat, sc, ni, el, es, ei;
        pipe_t li, ed;
        int gaps[2] = '{10, 900};
        int want[2] = '{80, 320};
        spawn_period = 8'd1; speed = 4'd1;
        do_restart();
        for (int t = 0; t < 2; t++) begin
            rand_gap = 10'(gaps[t]);
            model_tick(el, es, ei, ed);
            run_tick(0, lat, sc, ni, li);
            checks++;
            if (ni !== 1 || int'(li.gap_y) !== want[t])
                begin failures++; $display("FAIL gap_clamp rand=%0d inserts=%0d got=%0d exp=%0d", gaps[t], ni, li.gap_y, want[t]); end
        end
        checks++;
        if (list_diff() !== 0) begin failures++; $display("FAIL gap_list diff=%0d exp=0", list_diff()); end
    endtask

    task automatic test_score();
        int lat, sc, ni, el, es, ei;
        pipe_t li, ed;
        int xs[$];
        spawn_period = 8'd100; speed = 4'd2; rand_gap = 10'd150;
        do_restart();
        xs = '{161};
        load_pipes(xs);
        model_tick(el, es, ei, ed);
        run_tick(0, lat, sc, ni, li);
        checks++;
        if (sc !== 1) begin failures++; $display("FAIL score_cross got=%0d exp=1", sc); end
        checks++;
        if (mem[0].x !== 11'sd159) begin failures++; $display("FAIL score_newx got=%0d exp=159", mem[0].x); end
        model_tick(el, es, ei, ed);
        run_tick(0, lat, sc, ni, li);
        checks++;
        if (sc !== 0) begin failures++; $display("FAIL score_again got=%0d exp=0", sc); end
        checks++;
        if (list_diff() !== 0) begin failures++; $display("FAIL score_list diff=%0d exp=0", list_diff()); end
    endtask

    task automatic test_remove();
        int lat, sc, ni, el, es, ei;
        pipe_t li, ed;
        int xs[$];
        spawn_period = 8'd100; speed = 4'd3;
        do_restart();
        xs = '{-50, 300};
        load_pipes(xs);
        model_tick(el, es, ei, ed);
        run_tick(0, lat, sc, ni, li);
        checks++;
        if (sc !== 0) begin failures++; $display("FAIL remove_noscore got=%0d exp=0", sc); end
        checks++;
        if (mem_n !== 2 || mem[0].x !== 11'sd297 || mem[1].x !== 11'sd640)
            begin failures++; $display("FAIL remove_list n=%0d x0=%0d x1=%0d exp n=2 x0=297 x1=640", mem_n, mem[0].x, mem[1].x); end
    endtask

    task automatic test_full();
        int lat, sc, ni, el, es, ei;
        pipe_t li, ed;
        int xs[$];
        spawn_period = 8'd5; speed = 4'd3; rand_gap = 10'd250;
        do_restart();
        for (int i = 0; i < 15; i++) xs.push_back(400);
        xs.push_back(-50);
        load_pipes(xs);
        model_tick(el, es, ei, ed);
        run_tick(0, lat, sc, ni, li);
        checks++;
        if (ni !== 0) begin failures++; $display("FAIL full_noinsert got=%0d exp=0", ni); end
        checks++;
        if (mem_n !== 15) begin failures++; $display("FAIL full_count got=%0d exp=15", mem_n); end
        checks++;
        if (lat !== 20) begin failures++; $display("FAIL full_latency got=%0d exp=20", lat); end
        model_tick(el, es, ei, ed);
        run_tick(0, lat, sc, ni, li);
        checks++;
        if (ni !== 1) begin failures++; $display("FAIL full_retry got=%0d exp=1", ni); end
        checks++;
        if (list_diff() !== 0) begin failures++; $display("FAIL full_list diff=%0d exp=0", list_diff()); end
    endtask

    task automatic test_not_running();
        int seen_busy = 0;
        running = 1'b0;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (busy || frame_done) seen_busy++;
            @(negedge clk);
        end
        checks++;
        if (seen_busy !== 0) begin failures++; $display("FAIL idle_tick busy_cycles=%0d exp=0", seen_busy); end
        running = 1'b1;
    endtask

    task automatic test_overrun();
        int lat, sc, ni, el, es, ei;
        pipe_t li, ed;
        int xs[$];
        spawn_period = 8'd2; speed = 4'd4;
        do_restart();
        xs = '{100, 200, 300, 400, 500, 600};
        load_pipes(xs);
        checks++;
        if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_pre got=%0b exp=0", overrun); end
        model_tick(el, es, ei, ed);
        run_tick(4, lat, sc, ni, li);
        checks++;
        if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_set got=%0b exp=1", overrun); end
        checks++;
        if (lat !== 10) begin failures++; $display("FAIL overrun_latency got=%0d exp=10", lat); end
        checks++;
        if (list_diff() !== 0) begin failures++; $display("FAIL overrun_list diff=%0d exp=0", list_diff()); end
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL overrun_no_extra_pass busy=%0b exp=0", busy); end
    endtask

    task automatic test_restart_mid();
        int xs[$];
        xs = '{100, 200, 300, 400, 500, 600};
        load_pipes(xs);
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk); @(negedge clk);
        restart = 1'b1;
        @(negedge clk); restart = 1'b0;
        checks++;
        if (list_clear !== 1'b1) begin failures++; $display("FAIL restart_clear_pulse got=%0b exp=1", list_clear); end
        @(negedge clk);
        checks++;
        if (list_clear !== 1'b0 || list_count !== 5'd0 || overrun !== 1'b0 || busy !== 1'b0)
            begin failures++; $display("FAIL restart_after clear=%0b count=%0d overrun=%0b busy=%0b exp 0 0 0 0", list_clear, list_count, overrun, busy); end
        exp_x.delete(); exp_g.delete(); exp_cnt = 0;
    endtask

    task automatic test_reset_mid();
        int xs[$];
        xs = '{150, 250, 350, 450, 550, 160};
        load_pipes(xs);
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk); @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin failures++; $display("FAIL resetmid_overrun got=%0b exp=1", overrun); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs_vec() !== 50'd0) begin failures++; $display("FAIL resetmid_outs got=%h exp=0", outs_vec()); end
        @(negedge clk); rst_n = 1'b1;
        do_restart();
    endtask

    task automatic test_random();
        int lat, sc, ni, el, es, ei;
        pipe_t li, ed;
        running = 1'b1;
        do_restart();
        for (int t = 0; t < 30; t++) begin
            speed = 4'($urandom_range(0, 15));
            spawn_period = 8'($urandom_range(0, 4));
            rand_gap = 10'($urandom_range(0, 1023));
            model_tick(el, es, ei, ed);
            run_tick(0, lat, sc, ni, li);
            checks++;
            if (lat !== el || sc !== es || ni !== ei)
                begin failures++; $display("FAIL rand_frame t=%0d lat=%0d/%0d score=%0d/%0d ins=%0d/%0d (got/exp)", t, lat, el, sc, es, ni, ei); end
            if (ei == 1) begin
                checks++;
                if (li !== ed) begin failures++; $display("FAIL rand_insdata t=%0d got x=%0d g=%0d exp x=%0d g=%0d", t, li.x, li.gap_y, ed.x, ed.gap_y); end
            end
            checks++;
            if (list_diff() !== 0) begin failures++; $display("FAIL rand_list t=%0d diff=%0d n=%0d exp_n=%0d", t, list_diff(), mem_n, exp_x.size()); end
        end
    endtask

    initial begin
        test_reset();
        test_spawn_cadence();
        test_gap_clamp();
        test_score();
        test_remove();
        test_full();
        test_not_running();
        test_overrun();
        test_restart_mid();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipes_scheduler.md
Name: pipes_scheduler

Overview:
Per-frame sequencer for pipes_list, the on-chip store of up to 16 pipe_t records. On each frame tick it does three things in order. It optionally spawns a new pipe at the right screen edge. It then runs one full iteration pass that scrolls every pipe left by the game speed. During that pass it removes pipes that have left the screen and emits a score pulse for each pipe that crosses the bird column. It sits between the frame timing generator and pipes_list, and is the only master of pipes_list's insert, iterate and clear ports.

Parameters:
SCREEN_W, 640, x coordinate assigned to newly spawned pipes.
PIPE_W, 52, pipe width in pixels; a pipe is off-screen when x < -PIPE_W.
BIRD_X, 160, bird column used for scoring.
GAP_MIN, 80, minimum gap_y; random values below it are clamped up.
GAP_MAX, 320, maximum gap_y; random values above it are clamped down.
CAPACITY, 16, pipes_list capacity; no insert is issued while count == CAPACITY.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
frame_tick  in  1  one-cycle pulse at start of vblank.
running  in  1  game active; ticks are ignored when low.
restart  in  1  one-cycle pulse that clears the list and the spawn timer.
speed  in  4  pixels scrolled per frame, 0..15.
spawn_period  in  8  frames between spawns; 0 is treated as 1.
rand_gap  in  10  random gap_y from the LFSR, sampled in SPAWN.
list_count  in  5  pipes_list count.
list_clear  out  1  drives pipes_list rst (active-high).
list_insert_en  out  1  pipes_list insert_en.
list_insert_data  out  pipe_t  pipes_list insert_data.
list_iter_start  out  1  pipes_list iter_start.
list_iter_done  in  1  pipes_list iter_done.
list_iter_out  in  pipe_t  current element from pipes_list.
list_iter_in  out  pipe_t  updated element written back to pipes_list.
list_iter_remove  out  1  drop the current element.
busy  out  1  high in every state except IDLE.
frame_done  out  1  one-cycle pulse when the pass completes.
score_inc  out  1  one-cycle pulse for each pipe that crosses BIRD_X.
overrun  out  1  sticky; set by a frame_tick that arrives while busy; cleared by restart.

Behaviour:
- Reset (async, rst_n = 0): state = IDLE, spawn_cnt = 0. All outputs are 0, including list_clear, overrun and list_insert_data.
- ce on pipes_list is tied to 1 at the top level. list_clear is registered and asserted for exactly 1 cycle, in the cycle after restart.
- States: IDLE, CLEAR, SPAWN, ITER_START, ITER, DONE.
- IDLE:
  - restart -> CLEAR. restart has priority over frame_tick.
  - frame_tick && running -> SPAWN.
  - frame_tick && !running -> ignored; no state change.
- CLEAR (1 cycle): list_clear = 1, spawn_cnt = 0, overrun = 0 -> IDLE.
- SPAWN (1 cycle):
  - If spawn_cnt == 0 and list_count < CAPACITY: list_insert_en = 1 with x = SCREEN_W and gap_y = clamp(rand_gap, GAP_MIN, GAP_MAX). Reload spawn_cnt = max(spawn_period, 1) - 1.
  - Else if spawn_cnt == 0 and the list is full: no insert, and spawn_cnt stays 0 so the spawn retries next frame.
  - Else: spawn_cnt decrements.
  - -> ITER_START in all cases.
- ITER_START (1 cycle): list_iter_start = 1 -> ITER.
- ITER:
  - pipes_list presents list_iter_out combinationally each cycle until list_iter_done.
  - Same-cycle combinational write-back: new_x = old_x - speed, in signed 11-bit arithmetic. list_iter_in = {new_x, old gap_y}.
  - list_iter_remove = (new_x < -PIPE_W).
  - score_inc = (old_x >= BIRD_X) && (new_x < BIRD_X), registered so it pulses 1 cycle later. A pipe that is removed and crosses BIRD_X in the same step still scores.
  - list_iter_done -> DONE. An empty list gives done in the first ITER cycle, with no write-back and no remove.
- DONE (1 cycle): frame_done = 1 -> IDLE.
- frame_tick while busy: no action except overrun = 1. The pass in progress completes unchanged.
- restart while busy: abort to CLEAR on the next edge. The partial pass is discarded because the list is cleared.
- Latency, tick to frame_done: 4 + N cycles for N stored pipes (N = 0 gives 4).

Decomposition:
- Package pipes_pkg (extends pipe_t.sv): pipe_t = {logic signed [10:0] x; logic [9:0] gap_y}, the state enum, and PIPE_W/BIRD_X/SCREEN_W defaults.
- No sub-modules. The clamp and the scroll/score comparator are inline combinational logic.

Test Plan:
- Reset, then running = 1, spawn_period = 3, speed = 2, four ticks -> inserts on ticks 1 and 4 only, each with x = 640. After tick 4, list x values = {634, 640}. frame_done fires once per tick.
- rand_gap = 10, then 900 -> inserted gap_y = 80, then 320.
- Pipe with x = 161, speed = 2 -> after one tick x = 159, and score_inc pulses exactly once. The next tick gives no pulse.
- Pipe with x = -50, speed = 3 -> new_x = -53 < -52, so remove is asserted and list_count drops by 1. Score does not pulse.
- Pre-fill 16 pipes, spawn due -> no insert_en, spawn_cnt stays 0. Remove one pipe -> the insert happens on the next tick.
- frame_tick during ITER -> overrun = 1 and the pass is unaffected. restart mid-ITER -> list_clear pulse, then list_count = 0 and overrun = 0. rst_n low mid-ITER -> all outputs 0 immediately.
